// File: rtl/simeck_pkg.sv
// Shared constants, FSM encoding and LFSR helpers for the Simeck round-constant generator.
// Everything here is elaboration-time only; no state lives in the package.
package simeck_pkg;

  localparam int SIMECK32_LFSR_W = 5;
  localparam int SIMECK32_ROUNDS = 32;
  localparam int SIMECK32_WORD   = 16;

  localparam int SIMECK48_LFSR_W = 5;
  localparam int SIMECK48_ROUNDS = 36;
  localparam int SIMECK48_WORD   = 24;

  localparam int SIMECK64_LFSR_W = 6;
  localparam int SIMECK64_ROUNDS = 44;
  localparam int SIMECK64_WORD   = 32;

  localparam int LFSR_MAX_W = 6;

  typedef logic [LFSR_MAX_W-1:0] lfsr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One forward step; bit k holds s_{i+k}, so bit 0 is the current z.
  function automatic lfsr_t lfsr_fwd(input lfsr_t state, input int w);
    lfsr_t nxt;
    nxt = '0;
    if (w == 6) begin
      nxt = {state[1] ^ state[0], state[5:1]};
    end else begin
      nxt = {1'b0, state[2] ^ state[0], state[4:1]};
    end
    return nxt;
  endfunction

  // State holding z_{rounds-1} in bit 0: the entry point of a reverse run.
  function automatic lfsr_t rev_start(input int w, input int rounds);
    lfsr_t s;
    s = (w == 6) ? 6'h3F : 6'h1F;
    for (int i = 0; i < rounds - 1; i++) begin
      s = lfsr_fwd(s, w);
    end
    return s;
  endfunction

endpackage

// File: rtl/simeck_const_gen_if.sv
// Consumer-facing bundle of the round-constant generator: control in, framed constant out.
// slave = generator side, master = key-schedule side.
interface simeck_const_gen_if #(
  parameter int WORD   = 16,
  parameter int ROUNDS = 32
);

  logic                        start;
  logic                        dir;
  logic                        step;
  logic                        valid;
  logic                        z;
  logic [WORD-1:0]             rc;
  logic [$clog2(ROUNDS)-1:0]   round;
  logic                        done;

  modport master (
    output start, dir, step,
    input  valid, z, rc, round, done
  );

  modport slave (
    input  start, dir, step,
    output valid, z, rc, round, done
  );

endinterface

// File: rtl/simeck_lfsr_core.sv
// Simeck z-sequence LFSR with forward/reverse initial loads and forward/reverse steps.
// Controls take effect on the next rising edge; load wins over step, nothing held means hold.
module simeck_lfsr_core
  import simeck_pkg::*;
#(
  parameter int LFSR_W = 5,
  parameter int ROUNDS = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic load_fwd_i,
  input  logic load_rev_i,
  input  logic step_fwd_i,
  input  logic step_rev_i,
  output logic z_o
);

  localparam lfsr_t FWD_INIT = lfsr_t'((1 << LFSR_W) - 1);
  localparam lfsr_t REV_INIT = rev_start(LFSR_W, ROUNDS);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;
  logic [LFSR_W-1:0] fwd_nxt;
  logic [LFSR_W-1:0] rev_nxt;

  // Reverse taps recover s_{i-1} from the forward recurrence solved for its oldest term.
  if (LFSR_W == 6) begin : g_w6
    assign fwd_nxt = {state_q[1] ^ state_q[0], state_q[5:1]};
    assign rev_nxt = {state_q[4:0], state_q[5] ^ state_q[0]};
  end else begin : g_w5
    assign fwd_nxt = {state_q[2] ^ state_q[0], state_q[4:1]};
    assign rev_nxt = {state_q[3:0], state_q[4] ^ state_q[1]};
  end

  always_comb begin
    state_d = state_q;
    if (load_fwd_i) begin
      state_d = FWD_INIT[LFSR_W-1:0];
    end else if (load_rev_i) begin
      state_d = REV_INIT[LFSR_W-1:0];
    end else if (step_fwd_i) begin
      state_d = fwd_nxt;
    end else if (step_rev_i) begin
      state_d = rev_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FWD_INIT[LFSR_W-1:0];
    end else begin
      state_q <= state_d;
    end
  end

  assign z_o = state_q[0];

endmodule

// File: rtl/simeck_const_gen.sv
// Simeck round-constant generator: first constant one cycle after start, one per accepted step.
// step low holds the current constant indefinitely; start restarts and drops a same-cycle step.
module simeck_const_gen
  import simeck_pkg::*;
#(
  parameter int LFSR_W = 5,
  parameter int ROUNDS = 32,
  parameter int WORD   = 16
) (
  input  logic              clk,
  input  logic              reset,
  simeck_const_gen_if.slave bus
);

  localparam int             RW   = $clog2(ROUNDS);
  localparam logic [RW-1:0]  LAST = RW'(ROUNDS - 1);

  state_e          state_q, state_d;
  logic            dir_q, dir_d;
  logic [RW-1:0]   round_q, round_d;
  logic            load_fwd, load_rev;
  logic            step_fwd, step_rev;
  logic            last_round;
  logic            z_raw;
  logic            run;

  simeck_lfsr_core #(
    .LFSR_W (LFSR_W),
    .ROUNDS (ROUNDS)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .load_fwd_i (load_fwd),
    .load_rev_i (load_rev),
    .step_fwd_i (step_fwd),
    .step_rev_i (step_rev),
    .z_o        (z_raw)
  );

  assign last_round = dir_q ? (round_q == '0) : (round_q == LAST);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    round_d  = round_q;
    load_fwd = 1'b0;
    load_rev = 1'b0;
    step_fwd = 1'b0;
    step_rev = 1'b0;

    if (bus.start) begin
      state_d  = ST_RUN;
      dir_d    = bus.dir;
      round_d  = bus.dir ? LAST : '0;
      load_fwd = ~bus.dir;
      load_rev = bus.dir;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.step) begin
            if (last_round) begin
              state_d = ST_DONE;
              round_d = '0;
            end else begin
              round_d  = dir_q ? round_q - 1'b1 : round_q + 1'b1;
              step_fwd = ~dir_q;
              step_rev = dir_q;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      round_q <= round_d;
    end
  end

  assign run       = (state_q == ST_RUN);
  assign bus.valid = run;
  assign bus.z     = run & z_raw;
  assign bus.rc    = run ? {{(WORD-2){1'b1}}, 1'b0, z_raw} : '0;
  assign bus.round = round_q;
  assign bus.done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_simeck_const_gen.sv
// Directed bench for Simeck32 (W=5, R=32) and Simeck64 (W=6, R=44) constant generators.
module tb_simeck_const_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst5, rst6;

  simeck_const_gen_if #(.WORD(16), .ROUNDS(32)) bus5();
  simeck_const_gen_if #(.WORD(32), .ROUNDS(44)) bus6();

  simeck_const_gen #(.LFSR_W(5), .ROUNDS(32), .WORD(16)) dut5 (
    .clk   (clk),
    .reset (rst5),
    .bus   (bus5)
  );

  simeck_const_gen #(.LFSR_W(6), .ROUNDS(44), .WORD(32)) dut6 (
    .clk   (clk),
    .reset (rst6),
    .bus   (bus6)
  );

  typedef struct {
    logic rst;
    logic st;
    logic d;
    logic sp;
    logic ev;
    logic ez;
    int   er;
    logic ed;
  } vec_t;

  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] z5_ref;
  logic        z6_ref [44];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic zref(input int sel, input int i);
    if (sel == 0) return z5_ref[31-i];
    return z6_ref[i];
  endfunction

  task automatic cyc(input int sel, input logic r, input logic st, input logic d, input logic sp);
    @(negedge clk);
    if (sel == 0) begin
      rst5 = r; bus5.start = st; bus5.dir = d; bus5.step = sp;
    end else begin
      rst6 = r; bus6.start = st; bus6.dir = d; bus6.step = sp;
    end
    @(posedge clk);
    #1;
  endtask

  // er < 0 means the round index is unspecified in that cycle.
  task automatic check_out(input int sel, input string tag, input logic ev, input logic ez,
                           input int er, input logic ed);
    logic [31:0] av, az, arc, ar, ad, erc;
    if (sel == 0) begin
      av = 32'(bus5.valid); az = 32'(bus5.z); arc = 32'(bus5.rc);
      ar = 32'(bus5.round); ad = 32'(bus5.done);
      erc = 32'h0000_FFFC;
    end else begin
      av = 32'(bus6.valid); az = 32'(bus6.z); arc = bus6.rc;
      ar = 32'(bus6.round); ad = 32'(bus6.done);
      erc = 32'hFFFF_FFFC;
    end
    erc[0] = ez;
    if (!ev) erc = '0;
    chk({tag, ".valid"}, av, 32'(ev));
    chk({tag, ".z"}, az, 32'(ev & ez));
    chk({tag, ".rc"}, arc, erc);
    if (er >= 0) chk({tag, ".round"}, ar, 32'(er));
    chk({tag, ".done"}, ad, 32'(ed));
  endtask

  task automatic full_run(input int sel, input logic d, input string tag);
    int r = (sel == 0) ? 32 : 44;
    int idx;
    for (int k = 0; k < r; k++) begin
      idx = d ? r - 1 - k : k;
      check_out(sel, $sformatf("%s.r%0d", tag, idx), 1'b1, zref(sel, idx), idx, 1'b0);
      cyc(sel, 1'b0, 1'b0, d, 1'b1);
    end
    check_out(sel, {tag, ".end"}, 1'b0, 1'b0, -1, 1'b1);
  endtask

  task automatic add(input logic rst, input logic st, input logic d, input logic sp,
                     input logic ev, input logic ez, input int er, input logic ed);
    vec_t v;
    v.rst = rst; v.st = st; v.d = d; v.sp = sp;
    v.ev = ev; v.ez = ez; v.er = er; v.ed = ed;
    tbl.push_back(v);
  endtask

  initial begin
    int   idx;
    int   sp;
    logic fin;
    logic [11:0] pre6;

    rst5 = 1'b1; rst6 = 1'b1;
    bus5.start = 1'b0; bus5.dir = 1'b0; bus5.step = 1'b0;
    bus6.start = 1'b0; bus6.dir = 1'b0; bus6.step = 1'b0;

    z5_ref = 32'b11111000110111010100001001011001;
    for (int i = 0; i < 6; i++) z6_ref[i] = 1'b1;
    for (int i = 6; i < 44; i++) z6_ref[i] = z6_ref[i-5] ^ z6_ref[i-6];

    // W=5: reset, idle step ignored, forward run, reverse run with dir wiggling mid-run.
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, zref(0, 0), 0, 0);
    for (int k = 0; k < 32; k++) begin
      if (k < 31) add(0, 0, 0, 1, 1, zref(0, k + 1), k + 1, 0);
      else        add(0, 0, 0, 1, 0, 0, -1, 1);
    end
    add(0, 0, 0, 1, 0, 0, -1, 0);
    add(0, 1, 1, 0, 1, zref(0, 31), 31, 0);
    add(0, 0, 1, 0, 1, zref(0, 31), 31, 0);
    for (int k = 0; k < 32; k++) begin
      if (k < 31) add(0, 0, k[0], 1, 1, zref(0, 30 - k), 30 - k, 0);
      else        add(0, 0, k[0], 1, 0, 0, -1, 1);
    end
    add(0, 0, 0, 0, 0, 0, -1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(0, tbl[i].rst, tbl[i].st, tbl[i].d, tbl[i].sp);
      check_out(0, $sformatf("vec%0d", i), tbl[i].ev, tbl[i].ez, tbl[i].er, tbl[i].ed);
    end

    // Restart at round 10 with a simultaneous step, then restart on the done cycle.
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 1);
    check_out(0, "rs.r10", 1'b1, zref(0, 10), 10, 1'b0);
    cyc(0, 0, 1, 0, 1);
    full_run(0, 1'b0, "rs.fwd");
    cyc(0, 0, 1, 1, 0);
    full_run(0, 1'b1, "rs.rev");
    cyc(0, 0, 0, 0, 0);
    check_out(0, "rs.idle", 1'b0, 1'b0, -1, 1'b0);

    // Random step gaps: constant must hold while step is low, none skipped or repeated.
    cyc(0, 0, 1, 0, 0);
    idx = 0;
    fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      check_out(0, $sformatf("stall.c%0d", c), 1'b1, zref(0, idx), idx, 1'b0);
      sp = $urandom_range(0, 1);
      cyc(0, 0, 0, 0, sp[0]);
      if (sp[0]) idx++;
      if (idx == 32) begin
        check_out(0, "stall.end", 1'b0, 1'b0, -1, 1'b1);
        fin = 1'b1;
      end
    end
    chk("stall.budget", 32'(fin), 32'd1);
    cyc(0, 0, 0, 0, 0);

    // Reset at round 17: outputs clear, no done pulse, then a clean full run.
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 17; k++) cyc(0, 0, 0, 0, 1);
    check_out(0, "rst.r17", 1'b1, zref(0, 17), 17, 1'b0);
    cyc(0, 1, 1, 0, 1);
    check_out(0, "rst.now", 1'b0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 0, 1);
      check_out(0, $sformatf("rst.quiet%0d", k), 1'b0, 1'b0, -1, 1'b0);
    end
    cyc(0, 0, 1, 0, 0);
    full_run(0, 1'b0, "rst.again");

    // W=6, R=44, WORD=32.
    cyc(1, 1, 0, 0, 0);
    check_out(1, "w6.reset", 1'b0, 1'b0, 0, 1'b0);
    cyc(1, 0, 1, 0, 0);
    pre6 = '0;
    for (int k = 0; k < 12; k++) begin
      pre6[11-k] = bus6.z;
      cyc(1, 0, 0, 0, 1);
    end
    chk("w6.prefix", 32'(pre6), 32'h0000_0FC1);
    cyc(1, 0, 1, 0, 0);
    full_run(1, 1'b0, "w6.fwd");
    cyc(1, 0, 0, 0, 0);
    check_out(1, "w6.idle", 1'b0, 1'b0, -1, 1'b0);
    cyc(1, 0, 1, 1, 0);
    full_run(1, 1'b1, "w6.rev");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/simeck_const_gen.md
# simeck_const_gen

- Parametrised round-constant generator for the Simeck key schedule.
- Produces the z-sequence bit and the full constant word C⊕z, one round per `step`, for Simeck32/64, 48/96 and 64/128.
- Runs forward (encryption order) or reverse (decryption order) and frames the sequence with round index, `valid` and `done`.
- Feeds the key-schedule datapath; replaces the fixed 5-bit single-direction LFSR.

## Interface
Parameters:
- `LFSR_W`, 5, LFSR width. 5 selects polynomial x^5+x^2+1; 6 selects x^6+x+1. No other values are legal.
- `ROUNDS`, 32, sequence length: 32 / 36 / 44 for Simeck32 / 48 / 64.
- `WORD`, 16, key word width n: 16 / 24 / 32.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a new sequence; sampled every cycle.
- `dir`  in  1  sampled with `start`. 0 = forward (z_0 … z_{R-1}); 1 = reverse (z_{R-1} … z_0).
- `step`  in  1  consumer accepted the current constant; advance one round.
- `valid`  out  1  `z`, `rc` and `round` are meaningful.
- `z`  out  1  current sequence bit; 0 when `valid`=0.
- `rc`  out  WORD  {(WORD-2) ones, 1'b0, z}, i.e. 2^n−4 ⊕ z; 0 when `valid`=0.
- `round`  out  $clog2(ROUNDS)  index of the current constant: 0…R-1 forward, R-1…0 reverse.
- `done`  out  1  one-cycle pulse after the last constant is consumed.

## Operation
- Fibonacci LFSR state s[LFSR_W-1:0], where s[k] = s_{i+k}; output z_i = s[0].
- Forward step, W=5: s ← {s[2]^s[0], s[4:1]}. W=6: s ← {s[1]^s[0], s[5:1]}.
- Reverse step, W=5: s ← {s[3:0], s[4]^s[1]}. W=6: s ← {s[4:0], s[5]^s[0]}.
- Forward start state: all ones.
- Reverse start state: the state at index R-1. It is a package constant function evaluated at elaboration (iterate the forward step R-1 times from all ones). No runtime fast-forward.
- FSM states:
  - IDLE: `valid`=0. `start` → RUN.
  - RUN: `valid`=1. `step` on the last round → DONE. `start` → RUN (restart).
  - DONE: lasts exactly 1 cycle, `done`=1, `valid`=0. Then IDLE, or RUN if `start` is asserted.
- Round counter:
  - Forward: starts at 0, increments per step.
  - Reverse: starts at R-1, decrements per step.
  - The last round is `round`=R-1 forward, 0 reverse.
- `step` is ignored in IDLE and DONE. The LFSR never advances without `valid`.
- `start` has priority over `step` in the same cycle: the sequence restarts and the step is dropped.
- `dir` changes while running have no effect until the next `start`.
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.

## Timing
- Reset values: `valid`=0, `z`=0, `rc`=0, `round`=0, `done`=0; state IDLE; LFSR all ones.
- `start` high in cycle t → in cycle t+1: `valid`=1, `round`=0 (or R-1), `z`=z_0 (or z_{R-1}).
- `step` high in cycle t with `valid`=1 → the next constant is presented in t+1. Full throughput is one constant per cycle.
- `step` held high from the first `valid` → `valid` lasts R cycles, then `done` pulses in the following cycle.
- `step` low → the current constant is held indefinitely.
- `reset` mid-sequence → reset values next cycle, regardless of `start` or `step`.

## Structure
- Shared package `simeck_pkg` holds:
  - per-variant constants: LFSR_W, ROUNDS, WORD for Simeck32/48/64;
  - FSM state enum (IDLE, RUN, DONE);
  - function `lfsr_fwd(state, w)`;
  - constant function `rev_start(w, rounds)`.
- One sub-module: `simeck_lfsr_core`. It holds the LFSR register with load-forward-init, load-reverse-init, step-forward and step-reverse controls. The top level holds the FSM, the round counter and the output formatting.

## Test plan
- W=5, R=32, forward, `step` held high:
  - z stream = 11111000110111010100001001011001;
  - `rc` = 0xFFFD / 0xFFFC accordingly;
  - `done` pulses in the cycle after round 31.
- W=5, R=32, reverse, `step` held high → the exact bit-reverse of the stream above. `round` runs 31→0.
- W=6, R=44, WORD=32, forward:
  - first 12 z bits = 111111000001;
  - full 44-bit stream matches the software model;
  - the stream reversed matches the reverse run.
- Stalls: random `step` gaps → `z`, `rc` and `round` stay stable while `step`=0; no constant is skipped or repeated.
- `start` asserted at round 10 together with `step`=1 → next cycle `round`=0 and z=z_0. Assert `start` on the `done` cycle and confirm a clean second run.
- `reset` asserted at round 17 → next cycle all outputs at reset values, `done` never pulses; a following `start` gives a correct full sequence.
